// File: rtl/sift_uart_pkg.sv
// Shared definitions for the BRAM-to-UART streamer.
//   state_t  : streamer FSM states
//   nb_bytes : bytes needed to carry one word of the given bit width
package sift_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_FETCH  = 3'd2,
    S_BYTE   = 3'd3,
    S_TXWAIT = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  function automatic int unsigned nb_bytes(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter.
//   clk, rst : clock, synchronous active-high reset
//   data_i   : byte to send, captured when start_i is seen while idle
//   start_i  : one-cycle send request
//   done_o   : high while idle (ready for a new byte)
//   tx       : serial line, idle high
module uart_tx #(
  parameter int unsigned CLOCKS_PER_BAUD = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       tx
);

  localparam int unsigned BCW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;

  logic [8:0]     shreg;
  logic [3:0]     bits_left;
  logic [BCW-1:0] baud_cnt;

  // Start bit is driven on acceptance; data bits then stop bit follow from shreg.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx        <= 1'b1;
      done_o    <= 1'b1;
      shreg     <= '0;
      bits_left <= '0;
      baud_cnt  <= '0;
    end else if (done_o) begin
      if (start_i) begin
        tx        <= 1'b0;
        shreg     <= {1'b1, data_i};
        bits_left <= 4'd9;
        baud_cnt  <= '0;
        done_o    <= 1'b0;
      end
    end else if (baud_cnt == BCW'(CLOCKS_PER_BAUD - 1)) begin
      baud_cnt <= '0;
      if (bits_left == 4'd0) begin
        done_o <= 1'b1;
      end else begin
        tx        <= shreg[0];
        shreg     <= {1'b0, shreg[8:1]};
        bits_left <= bits_left - 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + BCW'(1);
    end
  end

endmodule

// File: rtl/stream_bram_uart.sv
// Streams a burst of BRAM words out of a UART, MSB byte first, with an
// optional header byte before each burst.
//   clk, rst_in          : clock, synchronous active-high reset
//   start_in             : one-cycle burst request (accepted only when idle)
//   base_addr_in,count_in: first word address and number of words
//   data, address        : BRAM read data / read address
//   tx                   : UART serial output
//   busy_out, done_out   : burst in progress / one-cycle end-of-burst pulse
module stream_bram_uart
  import sift_uart_pkg::*;
#(
  parameter int unsigned BRAM_LENGTH     = 1000,
  parameter int unsigned BIT_DEPTH       = 13,
  parameter int unsigned BRAM_LATENCY    = 2,
  parameter int unsigned CLOCKS_PER_BAUD = 50,
  parameter int unsigned SEND_HEADER     = 1,
  parameter logic [7:0]  HEADER_BYTE     = 8'hA5
) (
  input  logic                               clk,
  input  logic                               rst_in,
  input  logic                               start_in,
  input  logic [$clog2(BRAM_LENGTH)-1:0]     base_addr_in,
  input  logic [$clog2(BRAM_LENGTH+1)-1:0]   count_in,
  input  logic [BIT_DEPTH-1:0]               data,
  output logic [$clog2(BRAM_LENGTH)-1:0]     address,
  output logic                               tx,
  output logic                               busy_out,
  output logic                               done_out
);

  localparam int unsigned AW = $clog2(BRAM_LENGTH);
  localparam int unsigned CW = $clog2(BRAM_LENGTH + 1);
  localparam int unsigned NB = nb_bytes(BIT_DEPTH);
  localparam int unsigned WW = NB * 8;
  localparam int unsigned LW = 3;

  state_t         state, state_d;
  logic [AW-1:0]  next_addr, next_addr_d, address_d;
  logic [CW-1:0]  remaining, remaining_d;
  logic [WW-1:0]  word, word_d, word_shift;
  logic [1:0]     byte_idx, byte_idx_d;
  logic [LW-1:0]  lat_cnt, lat_cnt_d;
  logic           hdr_phase, hdr_phase_d;
  logic           seen_busy, seen_busy_d;
  logic           uart_start, uart_start_d;
  logic [7:0]     uart_byte, uart_byte_d;
  logic           uart_idle;
  logic           busy_d, done_d;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(BRAM_LENGTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // Current byte of the word register; byte_idx counts down so MSB goes first.
  assign word_shift = word >> {byte_idx, 3'b000};

  // Next-state and register updates.
  always_comb begin
    state_d      = state;
    next_addr_d  = next_addr;
    address_d    = address;
    remaining_d  = remaining;
    word_d       = word;
    byte_idx_d   = byte_idx;
    lat_cnt_d    = lat_cnt;
    hdr_phase_d  = hdr_phase;
    seen_busy_d  = seen_busy;
    uart_start_d = 1'b0;
    uart_byte_d  = uart_byte;

    case (state)
      S_IDLE: begin
        if (start_in) begin
          remaining_d = count_in;
          if (SEND_HEADER != 0) begin
            next_addr_d = base_addr_in;
            state_d     = S_HEADER;
          end else if (count_in == '0) begin
            state_d = S_FINISH;
          end else begin
            address_d   = base_addr_in;
            next_addr_d = addr_inc(base_addr_in);
            lat_cnt_d   = '0;
            state_d     = S_FETCH;
          end
        end
      end
      S_HEADER: begin
        if (uart_idle) begin
          uart_start_d = 1'b1;
          uart_byte_d  = HEADER_BYTE;
          hdr_phase_d  = 1'b1;
          seen_busy_d  = 1'b0;
          state_d      = S_TXWAIT;
        end
      end
      S_FETCH: begin
        if (lat_cnt == LW'(BRAM_LATENCY)) begin
          word_d      = WW'(data);
          remaining_d = remaining - CW'(1);
          byte_idx_d  = 2'(NB - 1);
          state_d     = S_BYTE;
        end else begin
          lat_cnt_d = lat_cnt + LW'(1);
        end
      end
      S_BYTE: begin
        if (uart_idle) begin
          uart_start_d = 1'b1;
          uart_byte_d  = word_shift[7:0];
          hdr_phase_d  = 1'b0;
          seen_busy_d  = 1'b0;
          state_d      = S_TXWAIT;
        end
      end
      S_TXWAIT: begin
        // The UART must be seen busy before its idle flag means "byte sent".
        if (!uart_idle) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy) begin
          if (!hdr_phase && byte_idx != 2'd0) begin
            byte_idx_d = byte_idx - 2'd1;
            state_d    = S_BYTE;
          end else if (remaining == '0) begin
            state_d = S_FINISH;
          end else begin
            address_d   = next_addr;
            next_addr_d = addr_inc(next_addr);
            lat_cnt_d   = '0;
            state_d     = S_FETCH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
    done_d = (state_d == S_FINISH);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state      <= S_IDLE;
      address    <= '0;
      next_addr  <= '0;
      remaining  <= '0;
      word       <= '0;
      byte_idx   <= '0;
      lat_cnt    <= '0;
      hdr_phase  <= 1'b0;
      seen_busy  <= 1'b0;
      uart_start <= 1'b0;
      uart_byte  <= '0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      state      <= state_d;
      address    <= address_d;
      next_addr  <= next_addr_d;
      remaining  <= remaining_d;
      word       <= word_d;
      byte_idx   <= byte_idx_d;
      lat_cnt    <= lat_cnt_d;
      hdr_phase  <= hdr_phase_d;
      seen_busy  <= seen_busy_d;
      uart_start <= uart_start_d;
      uart_byte  <= uart_byte_d;
      busy_out   <= busy_d;
      done_out   <= done_d;
    end
  end

  uart_tx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_uart (
    .clk    (clk),
    .rst    (rst_in),
    .data_i (uart_byte),
    .start_i(uart_start),
    .done_o (uart_idle),
    .tx     (tx)
  );

endmodule
